// File: rtl/controlador_busca.sv
// controlador_busca: instruction fetch sequencer.
// Owns the program counter and drives the instruction memory address.
// It registers each fetched word into a one-entry output stage that has a valid/ready handshake toward decode.
// It handles taken-branch redirects, PC wrap-around, and a sticky misaligned-target error.
// Optional feature: define PARADA_NOP_EN to halt fetch on the all-zero program terminator instead of presenting it.
module controlador_busca #(
    parameter logic [31:0] PC_INICIAL   = 32'h00000000,
    parameter int          NUM_PALAVRAS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] endereco,
    input  logic [31:0] instrucao,
    output logic [31:0] instr_saida,
    output logic [31:0] pc_saida,
    output logic        valida,
    input  logic        pronto,
    input  logic        desvio_tomado,
    input  logic [31:0] alvo_desvio,
    output logic        parar,
    output logic        erro_alinhamento,
    output logic [31:0] contador_instr
);

    localparam logic [1:0] INICIO = 2'd0;
    localparam logic [1:0] BUSCA  = 2'd1;
    localparam logic [1:0] PARADO = 2'd2;

    // NUM_PALAVRAS is a power of two, so wrapping modulo the memory size is a mask.
    localparam logic [31:0] MASCARA = 32'(NUM_PALAVRAS * 4 - 1);

    logic [1:0]  estado;
    logic [31:0] pc;
    logic [31:0] pc_prox;
    logic        em_busca;
    logic        aceite;
    logic        redir_ok;
    logic        redir_erro;
    logic        quer_carga;
    logic        terminador;
    logic        carga;
    logic        parada;

    assign endereco = pc;

    // Decode this cycle's action. Priority is redirect, then load, then stall.
    always_comb begin
        em_busca   = (estado == BUSCA);
        aceite     = em_busca && valida && pronto;
        redir_ok   = em_busca && desvio_tomado && (alvo_desvio[1:0] == 2'b00);
        redir_erro = em_busca && desvio_tomado && (alvo_desvio[1:0] != 2'b00);
        quer_carga = em_busca && !desvio_tomado && (!valida || pronto);
`ifdef PARADA_NOP_EN
        terminador = (instrucao == 32'h00000000);
`else
        terminador = 1'b0;
`endif
        carga      = quer_carga && !terminador;
        parada     = redir_erro || (quer_carga && terminador);
        pc_prox    = (pc + 32'd4) & MASCARA;
    end

    // Control state: FSM, valid flag, halt and sticky alignment error.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado           <= INICIO;
            valida           <= 1'b0;
            parar            <= 1'b0;
            erro_alinhamento <= 1'b0;
        end else begin
            case (estado)
                INICIO: estado <= BUSCA;
                BUSCA: begin
                    if (parada) begin
                        estado <= PARADO;
                        parar  <= 1'b1;
                        valida <= 1'b0;
                    end else if (redir_ok) begin
                        valida <= 1'b0;
                    end else if (carga) begin
                        valida <= 1'b1;
                    end
                    if (redir_erro) begin
                        erro_alinhamento <= 1'b1;
                    end
                end
                PARADO: valida <= 1'b0;
                default: estado <= INICIO;
            endcase
        end
    end

    // Program counter and output stage. The output stage holds during a stall, so decode sees stable data.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_INICIAL;
            instr_saida <= 32'h00000000;
            pc_saida    <= 32'h00000000;
        end else if (redir_ok) begin
            pc <= alvo_desvio;
        end else if (carga) begin
            instr_saida <= instrucao;
            pc_saida    <= pc;
            pc          <= pc_prox;
        end
    end

    // Count completed handshakes. An accept still counts when it coincides with a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            contador_instr <= 32'h00000000;
        end else if (aceite) begin
            contador_instr <= contador_instr + 32'd1;
        end
    end

endmodule

// File: tb/tb_controlador_busca.sv
// Directed testbench for controlador_busca.
// It uses two instances: dut with 256 words, and dut2 with 4 words to exercise wrap-around.
module tb_controlador_busca;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    logic [31:0] instr_saida;
    logic [31:0] pc_saida;
    logic        valida;
    logic        pronto;
    logic        desvio_tomado;
    logic [31:0] alvo_desvio;
    logic        parar;
    logic        erro_alinhamento;
    logic [31:0] contador_instr;

    logic        reset2;
    logic [31:0] endereco2;
    logic [31:0] instrucao2;
    logic [31:0] instr_saida2;
    logic [31:0] pc_saida2;
    logic        valida2;
    logic        pronto2;
    logic        parar2;
    logic        erro2;
    logic [31:0] contador2;

    logic [31:0] mem  [0:255];
    logic [31:0] mem2 [0:3];

    int testes = 0;
    int falhas = 0;

    always #5 clk = ~clk;

    assign instrucao  = mem[endereco[9:2]];
    assign instrucao2 = mem2[endereco2[3:2]];

    controlador_busca #(.PC_INICIAL(32'h0), .NUM_PALAVRAS(256)) dut (
        .clk(clk), .reset(reset), .endereco(endereco), .instrucao(instrucao),
        .instr_saida(instr_saida), .pc_saida(pc_saida), .valida(valida),
        .pronto(pronto), .desvio_tomado(desvio_tomado), .alvo_desvio(alvo_desvio),
        .parar(parar), .erro_alinhamento(erro_alinhamento), .contador_instr(contador_instr)
    );

    controlador_busca #(.PC_INICIAL(32'h0), .NUM_PALAVRAS(4)) dut2 (
        .clk(clk), .reset(reset2), .endereco(endereco2), .instrucao(instrucao2),
        .instr_saida(instr_saida2), .pc_saida(pc_saida2), .valida(valida2),
        .pronto(pronto2), .desvio_tomado(1'b0), .alvo_desvio(32'h0),
        .parar(parar2), .erro_alinhamento(erro2), .contador_instr(contador2)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        testes++;
        if (obs !== esp) begin
            falhas++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        for (int i = 0; i <= 10; i++) mem[i] = 32'h1000_0000 + i;
        mem[11] = 32'h0;
        for (int i = 0; i < 4; i++) mem2[i] = 32'hB000_0000 + i;

        reset = 1'b1; pronto = 1'b0; desvio_tomado = 1'b0; alvo_desvio = 32'h0;
        reset2 = 1'b1; pronto2 = 1'b0;
        tick(); tick();

        // Check the values held in reset.
        verifica("rst_valida", {31'b0, valida}, 32'h0);
        verifica("rst_parar", {31'b0, parar}, 32'h0);
        verifica("rst_erro", {31'b0, erro_alinhamento}, 32'h0);
        verifica("rst_cont", contador_instr, 32'h0);
        verifica("rst_end", endereco, 32'h0);
        verifica("rst_instr", instr_saida, 32'h0);
        verifica("rst_pcs", pc_saida, 32'h0);

        // Sequential fetch with pronto held at 1.
        reset = 1'b0; pronto = 1'b1;
        tick();
        verifica("inicio_valida", {31'b0, valida}, 32'h0);
        tick();
        for (int k = 0; k <= 10; k++) begin
            verifica("seq_valida", {31'b0, valida}, 32'h1);
            verifica("seq_pcs", pc_saida, 32'(k * 4));
            verifica("seq_instr", instr_saida, 32'h1000_0000 + 32'(k));
            verifica("seq_cont", contador_instr, 32'(k));
            tick();
        end
        verifica("seq_cont11", contador_instr, 32'd11);
`ifdef PARADA_NOP_EN
        verifica("nop_parar", {31'b0, parar}, 32'h1);
        verifica("nop_valida", {31'b0, valida}, 32'h0);
        verifica("nop_end", endereco, 32'h2C);
        tick(); tick();
        verifica("nop_end_hold", endereco, 32'h2C);
        verifica("nop_cont_hold", contador_instr, 32'd11);
`else
        verifica("zero_valida", {31'b0, valida}, 32'h1);
        verifica("zero_pcs", pc_saida, 32'h2C);
        verifica("zero_instr", instr_saida, 32'h0);
        verifica("zero_parar", {31'b0, parar}, 32'h0);
`endif

        // Stall while 0x08 is presented.
        reset = 1'b1; tick();
        reset = 1'b0; pronto = 1'b1;
        tick(); tick(); tick(); tick();
        verifica("st_pcs0", pc_saida, 32'h08);
        verifica("st_cont0", contador_instr, 32'd2);
        pronto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            verifica("st_pcs", pc_saida, 32'h08);
            verifica("st_instr", instr_saida, 32'h1000_0002);
            verifica("st_end", endereco, 32'h0C);
            verifica("st_valida", {31'b0, valida}, 32'h1);
            verifica("st_cont", contador_instr, 32'd2);
        end
        pronto = 1'b1;
        tick();
        verifica("st_resume", pc_saida, 32'h0C);
        verifica("st_resume_cont", contador_instr, 32'd3);

        // Redirect to 0x40 while 0x1C is presented.
        tick(); tick(); tick(); tick();
        verifica("rd_pcs", pc_saida, 32'h1C);
        verifica("rd_cont0", contador_instr, 32'd7);
        desvio_tomado = 1'b1; alvo_desvio = 32'h40;
        tick();
        desvio_tomado = 1'b0;
        verifica("rd_bolha", {31'b0, valida}, 32'h0);
        verifica("rd_end", endereco, 32'h40);
        verifica("rd_cont1", contador_instr, 32'd8);
        tick();
        verifica("rd_valida", {31'b0, valida}, 32'h1);
        verifica("rd_alvo", pc_saida, 32'h40);
        verifica("rd_instr", instr_saida, 32'hA000_0010);
        tick();
        verifica("rd_next", pc_saida, 32'h44);
        verifica("rd_cont2", contador_instr, 32'd9);

        // Misaligned redirect target.
        desvio_tomado = 1'b1; alvo_desvio = 32'h42;
        tick();
        verifica("mal_erro", {31'b0, erro_alinhamento}, 32'h1);
        verifica("mal_parar", {31'b0, parar}, 32'h1);
        verifica("mal_valida", {31'b0, valida}, 32'h0);
        verifica("mal_end", endereco, 32'h48);
        verifica("mal_cont", contador_instr, 32'd10);
        alvo_desvio = 32'h80;
        for (int k = 0; k < 3; k++) begin
            pronto = k[0];
            tick();
            verifica("par_end", endereco, 32'h48);
            verifica("par_valida", {31'b0, valida}, 32'h0);
            verifica("par_cont", contador_instr, 32'd10);
        end
        desvio_tomado = 1'b0;
        reset = 1'b1; tick();
        verifica("par_rst_erro", {31'b0, erro_alinhamento}, 32'h0);
        verifica("par_rst_parar", {31'b0, parar}, 32'h0);
        verifica("par_rst_end", endereco, 32'h0);

        // Assert reset during a stall.
        reset = 1'b0; pronto = 1'b1;
        tick(); tick(); tick();
        verifica("rs_pcs", pc_saida, 32'h04);
        pronto = 1'b0;
        tick();
        verifica("rs_valida", {31'b0, valida}, 32'h1);
        verifica("rs_cont", contador_instr, 32'd1);
        reset = 1'b1; pronto = 1'b1;
        tick();
        verifica("rs_valida0", {31'b0, valida}, 32'h0);
        verifica("rs_cont0", contador_instr, 32'h0);
        verifica("rs_pcs0", pc_saida, 32'h0);
        verifica("rs_instr0", instr_saida, 32'h0);

        // Wrap-around on a 4-word memory.
        reset2 = 1'b0; pronto2 = 1'b1;
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            verifica("wr_valida", {31'b0, valida2}, 32'h1);
            verifica("wr_pcs", pc_saida2, 32'((k % 4) * 4));
            verifica("wr_instr", instr_saida2, 32'hB000_0000 + 32'(k % 4));
            tick();
        end
        verifica("wr_cont", contador2, 32'd6);
        verifica("wr_parar", {31'b0, parar2}, 32'h0);
        verifica("wr_erro", {31'b0, erro2}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
